led_pwm: RTL and testbench
==========================

LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have parameter: size, 'h1000, byte size of decoded register window.
REQ-002 SHALL have parameter: channels, 8, number of LED outputs, legal 1..32.
REQ-003 SHALL have parameter: pwm_width, 8, PWM counter/duty width in bits, legal 1..16.
REQ-004 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: wb  wb_if slave modport  32-bit adr/dat, 4-bit sel  pipelined Wishbone slave (cyc, stb, we, adr, sel, dat_m, dat_s, ack, err, stall).
REQ-007 SHALL have port: led  output  channels  LED drive, 1 = on.

Function
REQ-008 SHALL decode adr modulo size, word offsets: 0x000 OUT, 0x004 MODE, 0x008 PRESCALE, 0x100+4*i DUTY[i] for i < channels.
REQ-009 SHALL tie stall to 0 and err to 0; every cycle with cyc&stb is one accepted request.
REQ-010 SHALL assert ack exactly one cycle after each accepted request; back-to-back requests give back-to-back acks.
REQ-011 SHALL drive dat_s with read data in the ack cycle; unused bits and unmapped offsets read 0.
REQ-012 SHALL write only bytes whose sel bit is 1; writes to unmapped offsets are acked and ignored.
REQ-013 OUT[channels-1:0], MODE[channels-1:0], PRESCALE[15:0], DUTY[i][pwm_width-1:0]: all read back as written.
REQ-014 SHALL run prescaler counter 0..PRESCALE; tick when counter equals PRESCALE, counter then returns to 0; PRESCALE=0 gives tick every cycle.
REQ-015 Any write to PRESCALE SHALL clear the prescaler counter in the same cycle the write takes effect.
REQ-016 SHALL advance a free-running pwm_width-bit counter by 1 per tick, wrapping from 2^pwm_width-1 to 0 (wrap = PWM period end).
REQ-017 Per channel: MODE[i]=0 -> led[i] = OUT[i]; MODE[i]=1 -> led[i] = (pwm counter < DUTY[i]), unsigned compare.
REQ-018 DUTY[i]=0 SHALL give led[i] constantly 0; DUTY[i]=2^pwm_width-1 SHALL give led[i] low for exactly one count per period.
REQ-019 led SHALL be registered: a register write affects led in the cycle after the ack cycle at the latest, with no glitch.
REQ-020 DUTY write mid-period SHALL take effect on the next comparison (no period-boundary shadowing).

Reset
REQ-021 While rst=1: ack=0, dat_s=0, led=0, OUT=MODE=PRESCALE=0, all DUTY=0, prescaler and PWM counters 0, blink state 0.
REQ-022 rst asserted mid-transaction SHALL drop any pending ack; requests presented while rst=1 are not acked.
REQ-023 First request accepted in the cycle after rst deasserts SHALL be acked normally.

Configuration
REQ-024 Macro LED_PWM_BLINK_EN defined SHALL add BLINK at 0x00C (bit i enables blink for channel i) and BLINK_DIV at 0x010 (16 bits).
REQ-025 With LED_PWM_BLINK_EN: a period counter counts PWM wraps; when it reaches BLINK_DIV it clears and toggles a phase bit; BLINK_DIV=0 toggles every wrap.
REQ-026 With LED_PWM_BLINK_EN: led[i] SHALL be forced 0 when BLINK[i]=1 and phase=0, else per REQ-017; BLINK, BLINK_DIV, phase reset to 0.
REQ-027 Without LED_PWM_BLINK_EN: 0x00C and 0x010 read 0, writes acked and ignored, no blink logic or masking present.

Verification
REQ-028 Reset, write OUT=0xA5, MODE=0 -> read OUT returns 0x000000A5, led=8'hA5 by cycle after ack.
REQ-029 channels=8, pwm_width=8, PRESCALE=0, MODE=0x01, DUTY[0]=64 -> led[0] high 64 of every 256 cycles, period 256 cycles.
REQ-030 PRESCALE=3, DUTY[1]=1, MODE=0x02 -> led[1] high 4 cycles per 1024-cycle period; DUTY=0 -> led[1] never high.
REQ-031 Three back-to-back stb (write DUTY[2], read DUTY[2], read 0x0FC) -> three consecutive acks, stall=0, reads return written value then 0; sel=4'b0001 write of 0xFFFF writes only byte 0.
REQ-032 LED_PWM_BLINK_EN defined, BLINK=0x01, BLINK_DIV=1, MODE=0, OUT=0x01, PRESCALE=0 -> led[0] alternates 512 cycles off / 512 cycles on; undefined -> led[0] constant 1 and 0x00C reads 0.
REQ-033 Assert rst for 1 cycle during an outstanding request with PWM active -> no ack, led=0, all registers read 0 afterwards.

Source files
------------

// File: rtl/led_pwm_if.sv
// Pipelined Wishbone bus bundle used by led_pwm: 32-bit address/data, byte selects.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, err, stall);
  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, err, stall);
endinterface

// File: rtl/led_pwm.sv
// led_pwm: Wishbone-mapped LED driver, static or PWM per channel, registered LED outputs.
// Optional blink gating (BLINK/BLINK_DIV registers) is built when LED_PWM_BLINK_EN is defined.
module led_pwm #(
  parameter int size      = 32'h0000_1000,
  parameter int channels  = 8,
  parameter int pwm_width = 8
) (
  input  logic                clk,
  input  logic                rst,
  wb_if.slave                 wb,
  output logic [channels-1:0] led
);

  localparam logic [31:0] OFF_OUT       = 32'h0000_0000;
  localparam logic [31:0] OFF_MODE      = 32'h0000_0004;
  localparam logic [31:0] OFF_PRESCALE  = 32'h0000_0008;
  localparam logic [31:0] OFF_BLINK     = 32'h0000_000C;
  localparam logic [31:0] OFF_BLINK_DIV = 32'h0000_0010;
  localparam logic [31:0] DUTY_BASE     = 32'h0000_0100;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel_v);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel_v[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else          res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0]          w_off;
  logic [31:0]          w_word;
  logic [31:0]          w_rdata;
  logic [31:0]          w_wdata;
  logic                 w_req;
  logic                 w_wr;
  logic                 w_prescale_wr;
  logic                 w_tick;
  logic                 w_wrap;
  logic                 w_unused;
  logic [channels-1:0]  w_duty_hit;
  logic [channels-1:0]  w_led;

  logic                 r_ack;
  logic [31:0]          r_dat_s;
  logic [channels-1:0]  r_out;
  logic [channels-1:0]  r_mode;
  logic [channels-1:0]  r_led;
  logic [15:0]          r_prescale;
  logic [15:0]          r_pre_cnt;
  logic [pwm_width-1:0] r_pwm_cnt;
  logic [pwm_width-1:0] r_duty [channels];

`ifdef LED_PWM_BLINK_EN
  logic [channels-1:0]  r_blink;
  logic [15:0]          r_blink_div;
  logic [15:0]          r_blk_cnt;
  logic                 r_phase;
`endif

  assign w_req         = wb.cyc & wb.stb;
  assign w_wr          = w_req & wb.we;
  assign w_off         = wb.adr % 32'(size);
  assign w_word        = {w_off[31:2], 2'b00};
  assign w_prescale_wr = w_wr & (w_word == OFF_PRESCALE);
  assign w_wdata       = byte_merge(w_rdata, wb.dat_m, wb.sel);
  assign w_tick        = (r_pre_cnt == r_prescale);
  assign w_wrap        = w_tick & (&r_pwm_cnt);
  // Fields narrower than 32 bits leave the upper merge bits and byte-offset bits unconsumed.
  assign w_unused      = ^{w_off[1:0], w_wdata};

  assign wb.ack   = r_ack;
  assign wb.dat_s = r_dat_s;
  assign wb.err   = 1'b0;
  assign wb.stall = 1'b0;
  assign led      = r_led;

  // Per-channel DUTY address match.
  always_comb begin
    w_duty_hit = '0;
    for (int i = 0; i < channels; i++) begin
      w_duty_hit[i] = (w_word == DUTY_BASE + 32'd4 * 32'(i));
    end
  end

  // Read mux; also the base value for byte-masked writes.
  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      OFF_OUT:       w_rdata = 32'(r_out);
      OFF_MODE:      w_rdata = 32'(r_mode);
      OFF_PRESCALE:  w_rdata = 32'(r_prescale);
`ifdef LED_PWM_BLINK_EN
      OFF_BLINK:     w_rdata = 32'(r_blink);
      OFF_BLINK_DIV: w_rdata = 32'(r_blink_div);
`endif
      default:       w_rdata = 32'd0;
    endcase
    for (int i = 0; i < channels; i++) begin
      w_rdata = w_rdata | (w_duty_hit[i] ? 32'(r_duty[i]) : 32'd0);
    end
  end

  // Bus response: one ack per accepted request, read data in the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_dat_s <= 32'd0;
    end else begin
      r_ack   <= w_req;
      r_dat_s <= (w_req & ~wb.we) ? w_rdata : 32'd0;
    end
  end

  // Control register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_mode     <= '0;
      r_prescale <= 16'd0;
      for (int i = 0; i < channels; i++) r_duty[i] <= '0;
`ifdef LED_PWM_BLINK_EN
      r_blink     <= '0;
      r_blink_div <= 16'd0;
`endif
    end else if (w_wr) begin
      case (w_word)
        OFF_OUT:       r_out       <= w_wdata[channels-1:0];
        OFF_MODE:      r_mode      <= w_wdata[channels-1:0];
        OFF_PRESCALE:  r_prescale  <= w_wdata[15:0];
`ifdef LED_PWM_BLINK_EN
        OFF_BLINK:     r_blink     <= w_wdata[channels-1:0];
        OFF_BLINK_DIV: r_blink_div <= w_wdata[15:0];
`endif
        default:       r_out       <= r_out;
      endcase
      for (int i = 0; i < channels; i++) begin
        if (w_duty_hit[i]) r_duty[i] <= w_wdata[pwm_width-1:0];
        else               r_duty[i] <= r_duty[i];
      end
    end else begin
      r_out <= r_out;
    end
  end

  // Prescaler and PWM counter; a PRESCALE write restarts the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= 16'd0;
      r_pwm_cnt <= '0;
    end else begin
      if (w_prescale_wr || w_tick) r_pre_cnt <= 16'd0;
      else                         r_pre_cnt <= r_pre_cnt + 16'd1;
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + pwm_width'(1'b1);
      else        r_pwm_cnt <= r_pwm_cnt;
    end
  end

`ifdef LED_PWM_BLINK_EN
  // Blink phase: toggles after BLINK_DIV+1 PWM periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt <= 16'd0;
      r_phase   <= 1'b0;
    end else if (w_wrap) begin
      if (r_blk_cnt == r_blink_div) begin
        r_blk_cnt <= 16'd0;
        r_phase   <= ~r_phase;
      end else begin
        r_blk_cnt <= r_blk_cnt + 16'd1;
      end
    end else begin
      r_blk_cnt <= r_blk_cnt;
    end
  end
`endif

  // Per-channel LED level before the output register.
  always_comb begin
    w_led = '0;
    for (int i = 0; i < channels; i++) begin
      w_led[i] = r_mode[i] ? (r_pwm_cnt < r_duty[i]) : r_out[i];
`ifdef LED_PWM_BLINK_EN
      w_led[i] = w_led[i] & ~(r_blink[i] & ~r_phase);
`endif
    end
  end

  // Glitch-free LED outputs.
  always_ff @(posedge clk) begin
    if (rst) r_led <= '0;
    else     r_led <= w_led;
  end

endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm: random register traffic against a register-map model,
// PWM duty measured over whole periods, back-to-back bus, byte selects, reset and blink.
module tb_led_pwm;
  localparam int CH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] led;
  int            vec_cnt = 0;
  int            err_cnt = 0;
  logic [31:0]   m_reg [0:1023];

  wb_if bus();

  led_pwm #(.size(32'h1000), .channels(CH), .pwm_width(8)) dut (
    .clk(clk), .rst(rst), .wb(bus), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Width of each register in the map (0 = unmapped).
  function automatic logic [31:0] reg_mask(input int idx);
    if (idx == 0 || idx == 1) return 32'h0000_00FF;
    if (idx == 2) return 32'h0000_FFFF;
`ifdef LED_PWM_BLINK_EN
    if (idx == 3) return 32'h0000_00FF;
    if (idx == 4) return 32'h0000_FFFF;
`endif
    if (idx >= 64 && idx < 64 + CH) return 32'h0000_00FF;
    return 32'h0000_0000;
  endfunction

  function automatic int widx(input logic [31:0] adr);
    return int'((adr % 32'h1000) >> 2);
  endfunction

  task automatic mdl_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int idx = widx(adr);
    for (int b = 0; b < 4; b++)
      if (sel[b]) m_reg[idx][8*b +: 8] = dat[8*b +: 8];
    m_reg[idx] = m_reg[idx] & reg_mask(idx);
  endtask

  function automatic logic [31:0] pick_addr();
    int r = int'($urandom_range(0, 15));
    logic [31:0] off;
    case (r)
      0: off = 32'h000;  1: off = 32'h004;  2: off = 32'h008;  3: off = 32'h00C;
      4: off = 32'h010;  5: off = 32'h0FC;  6: off = 32'h800;  15: off = 32'h120;
      default: off = 32'h100 + 32'(4 * (r - 7));
    endcase
    return off + 32'h1000 * 32'($urandom_range(0, 3));
  endfunction

  task automatic bus_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
    bus.adr = adr;  bus.dat_m = dat; bus.sel = sel;
    @(negedge clk);
    acked = bus.ack;
    rdat  = bus.dat_s;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    logic        ak;
    bus_cycle(1'b1, adr, dat, sel, rd, ak);
    chk("wr_ack", {31'd0, ak}, 32'd1);
    mdl_write(adr, dat, sel);
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ak;
    bus_cycle(1'b0, adr, 32'd0, 4'hF, rd, ak);
    chk({tag, "_ack"}, {31'd0, ak}, 32'd1);
    chk(tag, rd, exp);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 1024; k++) m_reg[k] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_dat", bus.dat_s, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    rst = 1'b0;
    clear_model();
  endtask

  // Over one exact PWM period, led[c] must be high DUTY*(PRESCALE+1) cycles in one run.
  task automatic pwm_window(input int c, input int d, input int p);
    int   highs = 0;
    int   rises = 0;
    int   others = 0;
    logic prv, cur;
    wb_wr(32'h000, 32'd0, 4'hF);
    wb_wr(32'h008, 32'(p), 4'hF);
    wb_wr(32'h004, 32'd1 << c, 4'hF);
    wb_wr(32'h100 + 32'(4 * c), 32'(d), 4'hF);
    repeat (3) @(negedge clk);
    prv = led[c];
    for (int k = 0; k < 256 * (p + 1); k++) begin
      @(negedge clk);
      cur = led[c];
      if (cur) highs++;
      if (cur && !prv) rises++;
      if ((led & ~(8'd1 << c)) != 8'd0) others++;
      prv = cur;
    end
    chk($sformatf("pwm_high_c%0d_d%0d_p%0d", c, d, p), 32'(highs), 32'(d * (p + 1)));
    chk($sformatf("pwm_runs_c%0d_d%0d", c, d), 32'(rises), (d != 0) ? 32'd1 : 32'd0);
    chk("pwm_other_ch", 32'(others), 32'd0);
  endtask

  initial begin
    logic [31:0] a, dv, stat_mask;
    logic [3:0]  s;
    int          highs, rises;
    logic        prv;

    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = 32'd0; bus.sel = 4'h0; bus.dat_m = 32'd0;
    clear_model();

    // Reset state and first access.
    do_reset();
    wb_rd("rst_out", 32'h000, 32'd0);
    wb_rd("rst_prescale", 32'h008, 32'd0);
    wb_rd("rst_duty7", 32'h11C, 32'd0);
    wb_wr(32'h000, 32'h0000_00A5, 4'hF);
    @(negedge clk);
    chk("out_led", {24'd0, led}, 32'h0000_00A5);
    wb_rd("out_rd", 32'h000, 32'h0000_00A5);

    // Random register traffic; static-mode channels must follow OUT.
    for (int n = 0; n < 40; n++) begin
      a  = pick_addr();
      dv = $urandom();
      s  = 4'($urandom_range(1, 15));
      wb_wr(a, dv, s);
      @(negedge clk);
      stat_mask = ~(m_reg[1] | m_reg[3]) & 32'h0000_00FF;
      chk("led_static", {24'd0, led} & stat_mask, m_reg[0] & stat_mask);
      a = pick_addr();
      wb_rd($sformatf("rand_rd_%03h", a[11:0]), a, m_reg[widx(a)]);
    end

    // Back-to-back: write DUTY[2], read DUTY[2], read unmapped 0x0FC.
    do_reset();
    dv = $urandom();
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h108; bus.dat_m = dv; bus.sel = 4'hF;
    @(negedge clk);
    chk("b2b_ack1", {31'd0, bus.ack}, 32'd1);
    chk("b2b_stall", {31'd0, bus.stall}, 32'd0);
    bus.we = 1'b0;
    @(negedge clk);
    chk("b2b_ack2", {31'd0, bus.ack}, 32'd1);
    chk("b2b_rd_duty2", bus.dat_s, dv & 32'h0000_00FF);
    bus.adr = 32'h0FC;
    @(negedge clk);
    chk("b2b_ack3", {31'd0, bus.ack}, 32'd1);
    chk("b2b_rd_0fc", bus.dat_s, 32'd0);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'd0, bus.ack}, 32'd0);

    // Byte-select write touches only byte 0.
    wb_wr(32'h008, 32'h0000_1234, 4'hF);
    wb_wr(32'h008, 32'h0000_FFFF, 4'b0001);
    wb_rd("sel_byte0", 32'h008, 32'h0000_12FF);

    // PWM duty over whole periods, including the extremes.
    do_reset();
    pwm_window(0, 64, 0);
    pwm_window(1, 1, 3);
    pwm_window(1, 0, 3);
    pwm_window(3, 255, 1);
    for (int n = 0; n < 3; n++)
      pwm_window(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 3)));

    // Blink gating, or its absence.
    do_reset();
`ifdef LED_PWM_BLINK_EN
    wb_wr(32'h00C, 32'h0000_0001, 4'hF);
    wb_wr(32'h010, 32'h0000_0001, 4'hF);
    wb_rd("blink_rd", 32'h00C, 32'h0000_0001);
`else
    wb_wr(32'h00C, 32'h0000_00FF, 4'hF);
    wb_wr(32'h010, 32'h0000_FFFF, 4'hF);
    wb_rd("blink_absent", 32'h00C, 32'd0);
    wb_rd("blinkdiv_absent", 32'h010, 32'd0);
`endif
    wb_wr(32'h004, 32'd0, 4'hF);
    wb_wr(32'h000, 32'h0000_0001, 4'hF);
    wb_wr(32'h008, 32'd0, 4'hF);
    repeat (3) @(negedge clk);
    highs = 0; rises = 0; prv = led[0];
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (led[0]) highs++;
      if (led[0] && !prv) rises++;
      prv = led[0];
    end
`ifdef LED_PWM_BLINK_EN
    chk("blink_on_cycles", 32'(highs), 32'd512);
    chk("blink_runs", 32'(rises), 32'd1);
`else
    chk("noblink_on_cycles", 32'(highs), 32'd1024);
`endif

    // Reset during an outstanding request with PWM running.
    wb_wr(32'h008, 32'd0, 4'hF);
    wb_wr(32'h004, 32'h0000_0001, 4'hF);
    wb_wr(32'h100, 32'd128, 4'hF);
    wb_wr(32'h000, 32'h0000_00F0, 4'hF);
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h000; bus.sel = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_mid_led", {24'd0, led}, 32'd0);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk("post_rst_ack", {31'd0, bus.ack}, 32'd1);
    chk("post_rst_out", bus.dat_s, 32'd0);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    wb_rd("post_rst_mode", 32'h004, 32'd0);
    wb_rd("post_rst_prescale", 32'h008, 32'd0);
    wb_rd("post_rst_duty0", 32'h100, 32'd0);
    @(negedge clk);
    chk("post_rst_led", {24'd0, led}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
